// File: rtl/l2_arb_pkg.sv
// Shared definitions for the L2 line-port arbiters.
//   StIdle / StBusy : arbiter FSM state encodings
//   ptr_width()     : width of a port index for a given port count (at least 1)
//   line_addr()     : line-granular address (byte address with the line offset removed)
package l2_arb_pkg;

    typedef logic [0:0] arb_state_t;

    localparam arb_state_t StIdle = 1'b0;
    localparam arb_state_t StBusy = 1'b1;

    function automatic int unsigned ptr_width(input int unsigned num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

    function automatic logic [31:0] line_addr(input logic [31:0] addr,
                                              input int unsigned s_offset);
        return addr >> s_offset;
    endfunction

endpackage

// File: rtl/l2_rr_arbiter_rr_picker.sv
// Combinational rotating-priority picker.
//   active     : per-port request vector
//   last_grant : most recently served port; search starts one above it and wraps
//   winner     : first active port in rotating order (0 when none active)
//   any_valid  : at least one port active
module rr_picker #(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned PTR_W     = 1
) (
    input  logic [NUM_PORTS-1:0] active,
    input  logic [PTR_W-1:0]     last_grant,
    output logic [PTR_W-1:0]     winner,
    output logic                 any_valid
);

    always_comb begin
        int idx;
        logic [PTR_W-1:0] idx_p;
        idx       = 0;
        idx_p     = '0;
        winner    = '0;
        any_valid = |active;
        // Walk from the farthest candidate back to the nearest so the nearest
        // active port (the highest rotating priority) is the last to write winner.
        for (int i = NUM_PORTS; i >= 1; i--) begin
            idx   = (int'(last_grant) + i) % int'(NUM_PORTS);
            idx_p = idx[PTR_W-1:0];
            if (active[idx_p]) begin
                winner = idx_p;
            end
        end
    end

endmodule

// File: rtl/l2_rr_arbiter.sv
// Round-robin arbiter between line-granular masters (L1 caches, prefetcher, DMA)
// and the shared L2 line port, with same-line read coalescing.
//   clk, rst_n               : clock, asynchronous active-low reset
//   req_read/req_write       : per-port level requests, held until req_resp
//   req_address/req_wdata    : per-port byte address and write line
//   req_resp                 : per-port one-cycle completion
//   req_rdata                : read line broadcast to all ports
//   l2_read/l2_write         : downstream level request from the granted port
//   l2_address/l2_wdata      : downstream address and write line
//   l2_resp/l2_rdata         : downstream one-cycle completion and read line
module l2_rr_arbiter
    import l2_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned S_OFFSET  = 5,
    parameter int unsigned S_LINE    = 256
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_PORTS-1:0]              req_read,
    input  logic [NUM_PORTS-1:0]              req_write,
    input  logic [NUM_PORTS-1:0][31:0]        req_address,
    input  logic [NUM_PORTS-1:0][S_LINE-1:0]  req_wdata,
    output logic [NUM_PORTS-1:0]              req_resp,
    output logic [S_LINE-1:0]                 req_rdata,
    output logic                              l2_read,
    output logic                              l2_write,
    output logic [31:0]                       l2_address,
    output logic [S_LINE-1:0]                 l2_wdata,
    input  logic                              l2_resp,
    input  logic [S_LINE-1:0]                 l2_rdata
);

    localparam int unsigned PtrW = ptr_width(NUM_PORTS);

    arb_state_t             state_q, state_d;
    logic [PtrW-1:0]        grant_q, grant_d;
    logic [PtrW-1:0]        last_q, last_d;

    logic [NUM_PORTS-1:0]   active;
    logic [PtrW-1:0]        winner;
    logic                   any_valid;
    logic                   busy;
    logic                   gnt_read;
    logic                   gnt_write;
    logic [31:0]            gnt_line;

    // A port asserting both read and write is served as a write.
    assign active = req_read | req_write;

    rr_picker #(
        .NUM_PORTS (NUM_PORTS),
        .PTR_W     (PtrW)
    ) u_picker (
        .active     (active),
        .last_grant (last_q),
        .winner     (winner),
        .any_valid  (any_valid)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                if (any_valid) begin
                    grant_d = winner;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                // Always return to idle: one dead cycle lets requesters deassert.
                if (l2_resp) begin
                    last_d  = grant_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            grant_q <= '0;
            last_q  <= PtrW'(NUM_PORTS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    assign busy = (state_q == StBusy);

    // Live view of the granted port: if it drops its request the L2 strobes fall
    // while the grant itself is kept.
    assign gnt_write = busy & req_write[grant_q];
    assign gnt_read  = busy & req_read[grant_q] & ~req_write[grant_q];
    assign gnt_line  = line_addr(req_address[grant_q], S_OFFSET);

    assign l2_read    = gnt_read;
    assign l2_write   = gnt_write;
    assign l2_address = busy ? req_address[grant_q] : '0;
    assign l2_wdata   = busy ? req_wdata[grant_q] : '0;
    assign req_rdata  = busy ? l2_rdata : '0;

    always_comb begin
        req_resp = '0;
        if (busy && l2_resp) begin
            req_resp[grant_q] = 1'b1;
            // A completed read also satisfies any pure read of the same line.
            if (gnt_read) begin
                for (int j = 0; j < int'(NUM_PORTS); j++) begin
                    if (int'(grant_q) != j && req_read[j] && !req_write[j] &&
                        line_addr(req_address[j], S_OFFSET) == gnt_line) begin
                        req_resp[j] = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_l2_rr_arbiter.sv
// Self-checking bench for l2_rr_arbiter (4 ports, 32-byte lines).
module tb_l2_rr_arbiter;

    localparam int N  = 4;
    localparam int SL = 256;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [N-1:0]        req_read;
    logic [N-1:0]        req_write;
    logic [N-1:0][31:0]  req_address;
    logic [N-1:0][SL-1:0] req_wdata;
    logic [N-1:0]        req_resp;
    logic [SL-1:0]       req_rdata;
    logic                l2_read;
    logic                l2_write;
    logic [31:0]         l2_address;
    logic [SL-1:0]       l2_wdata;
    logic                l2_resp;
    logic [SL-1:0]       l2_rdata;

    l2_rr_arbiter #(
        .NUM_PORTS (N),
        .S_OFFSET  (5),
        .S_LINE    (SL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_read    (req_read),
        .req_write   (req_write),
        .req_address (req_address),
        .req_wdata   (req_wdata),
        .req_resp    (req_resp),
        .req_rdata   (req_rdata),
        .l2_read     (l2_read),
        .l2_write    (l2_write),
        .l2_address  (l2_address),
        .l2_wdata    (l2_wdata),
        .l2_resp     (l2_resp),
        .l2_rdata    (l2_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]   addr;
        logic          wr;
        logic [SL-1:0] wdata;
    } l2_exp_t;

    typedef struct {
        logic [N-1:0]  vec;
        logic [SL-1:0] rdata;
        logic          chk;
    } resp_exp_t;

    l2_exp_t     exp_l2[$];
    resp_exp_t   exp_resp[$];
    int          n_pass = 0;
    int          n_total = 0;
    int          lat = 4;
    int          illegal_cnt = 0;
    int          refill[N];
    logic [31:0] next_addr[N];

    function automatic logic [SL-1:0] mk_line(input logic [31:0] a);
        if (a[31:5] == 27'h80) return {32{8'hA5}};
        return {8{a ^ 32'h5A5A_0000}};
    endfunction

    task automatic check(input string name, input logic [SL-1:0] act,
                         input logic [SL-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic fail_msg(input string name, input string detail);
        n_total++;
        $display("FAIL %s: %s", name, detail);
    endtask

    task automatic push_l2(input logic [31:0] a, input logic wr, input logic [SL-1:0] wd);
        l2_exp_t x;
        x.addr = a; x.wr = wr; x.wdata = wd;
        exp_l2.push_back(x);
    endtask

    task automatic push_resp(input logic [N-1:0] v, input logic [SL-1:0] rd, input logic c);
        resp_exp_t e;
        e.vec = v; e.rdata = rd; e.chk = c;
        exp_resp.push_back(e);
    endtask

    // One requester cycle: ports that saw req_resp drop (or reload) their request.
    task automatic tick();
        logic [N-1:0] done;
        @(negedge clk); #2;
        done = req_resp;
        @(posedge clk); #1;
        for (int j = 0; j < N; j++) begin
            if (done[j]) begin
                req_read[j]  = 1'b0;
                req_write[j] = 1'b0;
                if (refill[j] != 0) begin
                    refill[j]--;
                    next_addr[j]   = next_addr[j] + 32'h1000;
                    req_read[j]    = 1'b1;
                    req_address[j] = next_addr[j];
                end
            end
        end
    endtask

    task automatic reset_dut();
        rst_n     = 1'b0;
        req_read  = '0;
        req_write = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_drain(input int max);
        int i;
        i = 0;
        while ((exp_resp.size() != 0 || exp_l2.size() != 0 || req_read != 0 ||
                req_write != 0) && i < max) begin
            tick();
            i++;
        end
        if (i >= max) begin
            fail_msg("drain_timeout", $sformatf("%0d responses, %0d l2 requests outstanding",
                     exp_resp.size(), exp_l2.size()));
            exp_resp.delete();
            exp_l2.delete();
            req_read  = '0;
            req_write = '0;
        end
        tick();
        tick();
    endtask

    // L2 model: answers each transaction after lat busy cycles and checks the
    // issued request against the expected transaction sequence.
    initial begin
        int cnt;
        l2_exp_t x;
        cnt = 0;
        l2_resp  = 1'b0;
        l2_rdata = '0;
        forever begin
            @(negedge clk); #1;
            if (!rst_n) begin
                cnt = 0;
                l2_resp = 1'b0;
            end else if (l2_read || l2_write) begin
                cnt++;
                if (cnt == 1) begin
                    if (exp_l2.size() == 0) begin
                        fail_msg("l2_unexpected", $sformatf("request to %h", l2_address));
                    end else begin
                        x = exp_l2.pop_front();
                        check("l2_address", l2_address, x.addr);
                        check("l2_write", l2_write, x.wr);
                        if (x.wr) check("l2_wdata", l2_wdata, x.wdata);
                    end
                end
                if (cnt >= lat) begin
                    l2_resp  = 1'b1;
                    l2_rdata = l2_write ? '0 : mk_line(l2_address);
                    @(posedge clk); #1;
                    l2_resp  = 1'b0;
                    l2_rdata = '0;
                    cnt = 0;
                    @(negedge clk); #1;
                    if (rst_n) check("dead_cycle", {l2_read, l2_write}, 0);
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Response monitor / scoreboard.
    initial begin
        resp_exp_t e;
        forever begin
            @(negedge clk); #2;
            if (rst_n === 1'b1) begin
                check("l2_rw_exclusive", l2_read & l2_write, 0);
                if (req_resp != 0) begin
                    if (exp_resp.size() == 0) begin
                        fail_msg("resp_unexpected", $sformatf("req_resp=%b", req_resp));
                    end else begin
                        e = exp_resp.pop_front();
                        check("resp_vec", req_resp, e.vec);
                        if (e.chk) check("resp_rdata", req_rdata, e.rdata);
                    end
                end
            end
        end
    end

    // Illegal-request detector: read and write on the same port together.
    always @(negedge clk) begin
        if (rst_n && (req_read & req_write) != 0) begin
            if (illegal_cnt == 0) $display("note: port issued read and write together");
            illegal_cnt <= illegal_cnt + 1;
        end
    end

    initial begin
        #200000;
        fail_msg("watchdog", "simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b1;
        req_read    = '0;
        req_write   = '0;
        req_address = '0;
        req_wdata   = '0;
        for (int j = 0; j < N; j++) begin
            refill[j] = 0;
            next_addr[j] = '0;
        end

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("rst_req_resp", req_resp, 0);
        check("rst_l2_read", l2_read, 0);
        check("rst_l2_write", l2_write, 0);
        check("rst_l2_address", l2_address, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_req_rdata", req_rdata, 0);
        check("rst_l2_wdata", l2_wdata, 0);

        // Single read, 4-cycle L2 busy time
        lat = 4;
        req_read[0] = 1'b1;
        req_address[0] = 32'h0000_1000;
        push_l2(32'h0000_1000, 1'b0, '0);
        push_resp(4'b0001, {32{8'hA5}}, 1'b1);
        check("t1_idle_no_l2", l2_read, 0);
        tick();
        check("t1_grant_latency", l2_read, 1);
        check("t1_l2_address", l2_address, 32'h0000_1000);
        wait_drain(40);

        // All four ports streaming distinct lines
        reset_dut();
        lat = 2;
        for (int i = 0; i < 8; i++) begin
            push_l2(32'h4000 + 32'(i % 4) * 32'h100 + 32'(i / 4) * 32'h1000, 1'b0, '0);
            push_resp(4'(1 << (i % 4)),
                      mk_line(32'h4000 + 32'(i % 4) * 32'h100 + 32'(i / 4) * 32'h1000), 1'b1);
        end
        for (int j = 0; j < N; j++) begin
            next_addr[j]   = 32'h4000 + 32'(j) * 32'h100;
            req_address[j] = next_addr[j];
            refill[j]      = 1;
        end
        req_read = 4'b1111;
        wait_drain(80);

        // Same-line reads coalesce
        reset_dut();
        lat = 3;
        req_address[0] = 32'h100;
        req_address[1] = 32'h11C;
        req_read = 4'b0011;
        push_l2(32'h100, 1'b0, '0);
        push_resp(4'b0011, mk_line(32'h100), 1'b1);
        wait_drain(40);
        check("t3_no_second_read", {l2_read, l2_write}, 0);

        // Write never coalesces with a read of the same line
        reset_dut();
        lat = 2;
        req_address[0] = 32'h200;
        req_wdata[0]   = {8{32'hDEAD_0200}};
        req_write[0]   = 1'b1;
        req_address[1] = 32'h200;
        req_read[1]    = 1'b1;
        push_l2(32'h200, 1'b1, {8{32'hDEAD_0200}});
        push_resp(4'b0001, '0, 1'b0);
        push_l2(32'h200, 1'b0, '0);
        push_resp(4'b0010, mk_line(32'h200), 1'b1);
        wait_drain(40);

        // Reset while port 2 is granted; afterwards port 0 wins first
        reset_dut();
        lat = 10;
        req_address[2] = 32'h300;
        req_read[2]    = 1'b1;
        push_l2(32'h300, 1'b0, '0);
        repeat (3) tick();
        check("t5_busy_before_reset", l2_read, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_l2_read", l2_read, 0);
        check("t5_rst_l2_address", l2_address, 0);
        check("t5_rst_req_resp", req_resp, 0);
        check("t5_rst_req_rdata", req_rdata, 0);
        lat = 2;
        for (int j = 0; j < N; j++) begin
            req_address[j] = 32'h5000 + 32'(j) * 32'h100;
            push_l2(32'h5000 + 32'(j) * 32'h100, 1'b0, '0);
            push_resp(4'(1 << j), mk_line(32'h5000 + 32'(j) * 32'h100), 1'b1);
        end
        req_read = 4'b1111;
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_drain(60);

        // Read and write together on one port: served as a write
        reset_dut();
        lat = 3;
        req_address[1] = 32'h600;
        req_wdata[1]   = {8{32'hBEEF_0600}};
        req_read[1]    = 1'b1;
        req_write[1]   = 1'b1;
        push_l2(32'h600, 1'b1, {8{32'hBEEF_0600}});
        push_resp(4'b0010, '0, 1'b0);
        wait_drain(40);
        check("t6_illegal_flagged", illegal_cnt != 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/l2_rr_arbiter.md
# l2_rr_arbiter

Parametrised N-port arbiter between the split L1 caches (and any future line-granular masters such as a prefetcher or DMA) and the shared L2. It grants one requester at a time to the L2 line port using rotating round-robin priority, holds the grant until L2 responds, and coalesces completed L2 reads with any other pending read of the same line. This removes the fixed-order bias and the one-extra-read buffering of the two-port arbiter it replaces.

## Interface
- NUM_PORTS, 2, number of requesters (2..8)
- S_OFFSET, 5, log2 bytes per line; line address = address[31:S_OFFSET]
- S_LINE, 256, line width in bits (8 * 2**S_OFFSET)

- clk  in  1  rising-edge clock
- rst_n  in  1  reset; asynchronous, active-low
- req_read  in  NUM_PORTS  per-port line read request, level, held until req_resp
- req_write  in  NUM_PORTS  per-port line write request, level, held until req_resp
- req_address  in  NUM_PORTS x 32  per-port byte address
- req_wdata  in  NUM_PORTS x S_LINE  per-port write line
- req_resp  out  NUM_PORTS  per-port one-cycle completion
- req_rdata  out  S_LINE  read line, broadcast; valid with any req_resp bit for a read
- l2_read / l2_write  out  1  downstream request, level
- l2_address  out  32  downstream address
- l2_wdata  out  S_LINE  downstream write line
- l2_resp  in  1  downstream one-cycle completion
- l2_rdata  in  S_LINE  downstream read line, valid with l2_resp

## Operation
- Port active = req_read[i] | req_write[i]. If both set, the port is treated as a write (verification flags it as illegal).
- States: IDLE, BUSY.
- IDLE: if any port active, pick winner = first active port searching from (last_grant+1) mod NUM_PORTS upward with wrap; register grant <= winner; go BUSY. Else stay.
- BUSY: l2_read/l2_write/l2_address/l2_wdata driven combinationally from port grant. req_rdata = l2_rdata.
- BUSY and l2_resp: req_resp[grant] = 1; last_grant <= grant; go IDLE.
- Coalescing: if granted op is a read and l2_resp=1, every other port j with req_read[j]=1, req_write[j]=0 and req_address[j][31:S_OFFSET] == granted line address also gets req_resp[j]=1 the same cycle. Write completions never coalesce.
- last_grant updates only to the granted port, not to coalesced ports.
- Granted port dropping its request in BUSY before l2_resp is illegal; arbiter keeps grant and drives l2_read/l2_write low (assertion in bench).

## Timing
- Reset (rst_n low, any cycle, including mid-BUSY): state IDLE, last_grant = NUM_PORTS-1 (port 0 first priority), all outputs 0 (req_resp, l2_read, l2_write, l2_address); l2_wdata/req_rdata 0. An outstanding L2 transaction is abandoned; L2 is reset on the same net.
- Grant latency: request visible at edge n in IDLE -> l2_read/l2_write high from cycle n+1.
- req_resp is combinational from l2_resp (zero added latency), high exactly one cycle.
- Cycle after l2_resp is always IDLE: one dead cycle between back-to-back transactions, giving requesters one edge to deassert.
- Requests arriving during BUSY wait; they are evaluated in the next IDLE cycle.
- All N ports continuously active -> each port granted once every N transactions (starvation bound: N-1 transactions).

## Structure
- Package l2_arb_pkg: state enum (IDLE, BUSY), localparam PTR_W = $clog2(NUM_PORTS) helper, line-address extraction function.
- Sub-module rr_picker (combinational): inputs active vector and last_grant, outputs winner index and any_valid; reused later by the L2 writeback arbiter.
- Top holds state, grant, last_grant registers, output muxes, coalesce comparators.

## Test plan
- Reset then port 0 read 0x0000_1000, L2 resp after 3 cycles with line 0xA5..: l2_read high cycles 1-4, req_resp = 01 on resp cycle, req_rdata = 0xA5...
- NUM_PORTS=4, all ports read distinct lines continuously, L2 resp latency 2: grant order 0,1,2,3,0,1,...; each BUSY preceded by one IDLE.
- Port 0 reads 0x100, port 1 reads 0x11C (same 32-byte line) simultaneously: one L2 read to 0x100 only; req_resp = 11 same cycle; next IDLE cycle sees no requests.
- Port 0 writes 0x200 while port 1 reads 0x200: write granted first (port 0 priority), req_resp=01 only; then port 1 read issued, req_resp=10.
- rst_n asserted mid-BUSY (port 2 granted): outputs go 0 asynchronously; after release, port 0 wins first with all ports active.
- Port 1 asserts read and write together: bench assertion fires; arbiter issues l2_write.
